// File: rtl/mpadder_ctrl.sv
// mpadder_ctrl: sequencer for the chunked multi-precision adder.
// Drives CSA strobes, chunked resolve and bounded reduce passes.
module mpadder_ctrl #(
   parameter int NUM_CHUNKS = 5,
   parameter int MAX_SUB    = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       sub_finished,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       enableC,
   output logic       shift,
   output logic       enableCarry,
   output logic       subtract,
   output logic [3:0] chunk
);

   localparam int PW = $clog2(MAX_SUB + 1);
   localparam logic [3:0] LAST = 4'(NUM_CHUNKS - 1);
   localparam logic [PW-1:0] PLAST = PW'(MAX_SUB - 1);

   typedef enum logic [2:0] {
      IDLE, CSA, SHIFT, RES, SUB, DONE
   } state_t;

   state_t        state, state_n;
   logic [3:0]    chunk_q, chunk_n;
   logic [PW-1:0] pass_q, pass_n;
   logic          reduce_q, reduce_n;
   logic          err_q, err_n;

   // state and counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         chunk_q  <= '0;
         pass_q   <= '0;
         reduce_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         chunk_q  <= chunk_n;
         pass_q   <= pass_n;
         reduce_q <= reduce_n;
         err_q    <= err_n;
      end
   end

   // next state; pass_q counts failed subtract passes
   always_comb begin
      state_n  = state;
      chunk_n  = chunk_q;
      pass_n   = pass_q;
      reduce_n = reduce_q;
      err_n    = err_q;
      unique case (state)
         IDLE: begin
            if (start) begin
               reduce_n = op[1] & op[0];
               err_n    = 1'b0;
               pass_n   = '0;
               chunk_n  = '0;
               unique case (op)
                  2'b00:   state_n = CSA;
                  2'b01:   state_n = SHIFT;
                  default: state_n = RES;
               endcase
            end
         end
         CSA, SHIFT: state_n = DONE;
         RES: begin
            if (chunk_q == LAST) begin
               chunk_n = '0;
               state_n = reduce_q ? SUB : DONE;
            end else begin
               chunk_n = chunk_q + 4'd1;
            end
         end
         SUB: begin
            if (chunk_q == LAST) begin
               chunk_n = '0;
               if (sub_finished) begin
                  state_n = DONE;
               end else if (pass_q == PLAST) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  pass_n = pass_q + 1'b1;
               end
            end else begin
               chunk_n = chunk_q + 4'd1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign err         = err_q;
   assign enableC     = (state == CSA);
   assign shift       = (state == SHIFT);
   assign enableCarry = (state == RES) || (state == SUB);
   assign subtract    = (state == SUB);
   assign chunk       = chunk_q;

endmodule
